// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types, op decode and defaults for the memory stage
//
// Purpose: state encoding, ExOp bit positions, op-kind enum, stack-pointer
// update codes and the SP reset default shared by memory_stage and stack_pointer.
// Ports: none (package).

package mem_stage_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 20;
   localparam logic [ADDR_W_DEFAULT-1:0] SP_RESET_DEFAULT = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC1 = 2'd1,
      ST_ACC2 = 2'd2
   } state_t;

   // ExOp = {IN, LDD, STD, RTI, RET, CALL, POP, PUSH}
   localparam int OP_PUSH_BIT = 0;
   localparam int OP_POP_BIT  = 1;
   localparam int OP_CALL_BIT = 2;
   localparam int OP_RET_BIT  = 3;
   localparam int OP_RTI_BIT  = 4;
   localparam int OP_STD_BIT  = 5;
   localparam int OP_LDD_BIT  = 6;
   localparam int OP_IN_BIT   = 7;

   typedef enum logic [3:0] {
      K_ALU  = 4'd0,
      K_IN   = 4'd1,
      K_STD  = 4'd2,
      K_LDD  = 4'd3,
      K_POP  = 4'd4,
      K_PUSH = 4'd5,
      K_RTI  = 4'd6,
      K_RET  = 4'd7,
      K_CALL = 4'd8
   } op_kind_t;

   typedef enum logic [2:0] {
      SP_HOLD = 3'd0,
      SP_DEC1 = 3'd1,
      SP_DEC2 = 3'd2,
      SP_INC1 = 3'd3,
      SP_INC2 = 3'd4
   } sp_upd_t;

   // Several bits may be set at once; the highest-priority one wins.
   function automatic op_kind_t decode_op(input logic [7:0] op);
      if (op[OP_CALL_BIT]) return K_CALL;
      if (op[OP_RET_BIT])  return K_RET;
      if (op[OP_RTI_BIT])  return K_RTI;
      if (op[OP_PUSH_BIT]) return K_PUSH;
      if (op[OP_POP_BIT])  return K_POP;
      if (op[OP_LDD_BIT])  return K_LDD;
      if (op[OP_STD_BIT])  return K_STD;
      if (op[OP_IN_BIT])   return K_IN;
      return K_ALU;
   endfunction

   function automatic logic is_mem_op(input op_kind_t k);
      return (k != K_ALU) && (k != K_IN);
   endfunction

   function automatic logic is_two_word(input op_kind_t k);
      return (k == K_CALL) || (k == K_RET) || (k == K_RTI);
   endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - execute/memory/write-back signal bundle of the memory stage
//
// Purpose: groups the execute-side inputs, the 16-bit memory port and the
// write-back / PC-redirect outputs.
// Modports: slave = memory_stage view, master = surrounding pipeline/memory view.

interface memory_stage_if
   import mem_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);
   // execute side
   logic              ExValid;
   logic [7:0]        ExOp;
   logic              ExWB;
   logic [2:0]        ExRdstAddr;
   logic [15:0]       ExAluResult;
   logic [15:0]       ExRsrcValue;
   logic [15:0]       ExInPort;
   logic [31:0]       ExNextPC;
   logic              Stall;
   // memory port
   logic              MemReq;
   logic              MemWe;
   logic [ADDR_W-1:0] MemAddr;
   logic [15:0]       MemWData;
   logic [15:0]       MemRData;
   logic              MemReady;
   // write-back / redirect
   logic              WbValid;
   logic [15:0]       WbValue;
   logic [2:0]        WbRdstAddr;
   logic              PcLoad;
   logic [31:0]       PcTarget;
   logic              RtiDone;
   logic [ADDR_W-1:0] Sp;

   modport slave (
      input  ExValid, ExOp, ExWB, ExRdstAddr, ExAluResult, ExRsrcValue, ExInPort, ExNextPC,
      input  MemRData, MemReady,
      output Stall, MemReq, MemWe, MemAddr, MemWData,
      output WbValid, WbValue, WbRdstAddr, PcLoad, PcTarget, RtiDone, Sp
   );

   modport master (
      output ExValid, ExOp, ExWB, ExRdstAddr, ExAluResult, ExRsrcValue, ExInPort, ExNextPC,
      output MemRData, MemReady,
      input  Stall, MemReq, MemWe, MemAddr, MemWData,
      input  WbValid, WbValue, WbRdstAddr, PcLoad, PcTarget, RtiDone, Sp
   );

endinterface

// File: rtl/memory_stage_stack_pointer.sv
// rtl/memory_stage_stack_pointer.sv - word-addressed stack pointer register with wrap
//
// Purpose: holds SP; applies one of {hold, -1, -2, +1, +2} per cycle, modulo 2**ADDR_W.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset, loads SP_RESET
//   upd_i  - update code (sp_upd_t)
//   sp_o   - current stack pointer

module stack_pointer
   import mem_stage_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
   parameter logic [ADDR_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  sp_upd_t           upd_i,
   output logic [ADDR_W-1:0] sp_o
);

   logic [ADDR_W-1:0] sp_q;
   logic [ADDR_W-1:0] sp_d;

   // Plain ADDR_W-bit arithmetic gives the wrap for free.
   always_comb begin
      sp_d = sp_q;
      case (upd_i)
         SP_DEC1: sp_d = sp_q - ADDR_W'(1);
         SP_DEC2: sp_d = sp_q - ADDR_W'(2);
         SP_INC1: sp_d = sp_q + ADDR_W'(1);
         SP_INC2: sp_d = sp_q + ADDR_W'(2);
         default: sp_d = sp_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sp_q <= SP_RESET;
      end else begin
         sp_q <= sp_d;
      end
   end

   assign sp_o = sp_q;

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - data-memory / stack stage following execute
//
// Purpose: performs IN/ALU pass-through, LDD/STD, PUSH/POP and two-word
// CALL/RET/RTI stack transfers over a 16-bit req/ready memory port; produces a
// registered write-back bundle and a one-cycle PC redirect pulse.
// Ports:
//   CLK    - clock, rising edge
//   Reset  - synchronous active-high reset
//   bus    - memory_stage_if.slave: Ex* operands in, Stall out, Mem* port,
//            Wb*/PcLoad/PcTarget/RtiDone outputs, Sp

module memory_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
   parameter logic [ADDR_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
   input  logic          CLK,
   input  logic          Reset,
   memory_stage_if.slave bus
);

   state_t            state_q;
   op_kind_t          kind_q;
   logic              wb_q;
   logic [2:0]        rdst_q;
   logic [15:0]       alu_q;
   logic [15:0]       rsrc_q;
   logic [31:0]       npc_q;
   logic [15:0]       lo_q;

   logic              wb_valid_q;
   logic [15:0]       wb_value_q;
   logic [2:0]        wb_rdst_q;
   logic              pc_load_q;
   logic [31:0]       pc_target_q;
   logic              rti_done_q;

   logic [ADDR_W-1:0] sp;
   sp_upd_t           sp_upd_d;
   op_kind_t          ex_kind;
   logic              busy;
   logic              last_acc;
   logic              done;
   logic [ADDR_W-1:0] mem_addr_d;
   logic              mem_we_d;
   logic [15:0]       mem_wdata_d;

   assign ex_kind  = decode_op(bus.ExOp);
   assign busy     = (state_q != ST_IDLE);
   assign last_acc = (state_q == ST_ACC2) || ((state_q == ST_ACC1) && !is_two_word(kind_q));
   assign done     = busy && bus.MemReady && last_acc;

   // SP moves only on the edge that completes a memory op, so the stack
   // addresses below stay stable for the whole transfer.
   always_comb begin
      sp_upd_d = SP_HOLD;
      if (done) begin
         case (kind_q)
            K_PUSH:       sp_upd_d = SP_DEC1;
            K_POP:        sp_upd_d = SP_INC1;
            K_CALL:       sp_upd_d = SP_DEC2;
            K_RET, K_RTI: sp_upd_d = SP_INC2;
            default:      sp_upd_d = SP_HOLD;
         endcase
      end
   end

   stack_pointer #(
      .ADDR_W   (ADDR_W),
      .SP_RESET (SP_RESET)
   ) u_sp (
      .clk_i (CLK),
      .rst_i (Reset),
      .upd_i (sp_upd_d),
      .sp_o  (sp)
   );

   // Memory port is decoded from latched operands and the current state only.
   // CALL pushes the high word first; RET/RTI pops the low word first.
   always_comb begin
      mem_addr_d  = sp;
      mem_we_d    = 1'b0;
      mem_wdata_d = rsrc_q;
      case (kind_q)
         K_PUSH: mem_we_d = 1'b1;
         K_POP:  mem_addr_d = sp + ADDR_W'(1);
         K_LDD:  mem_addr_d = ADDR_W'(alu_q);
         K_STD: begin
            mem_addr_d = ADDR_W'(alu_q);
            mem_we_d   = 1'b1;
         end
         K_CALL: begin
            mem_we_d = 1'b1;
            if (state_q == ST_ACC2) begin
               mem_addr_d  = sp - ADDR_W'(1);
               mem_wdata_d = npc_q[15:0];
            end else begin
               mem_wdata_d = npc_q[31:16];
            end
         end
         K_RET, K_RTI: begin
            mem_addr_d = (state_q == ST_ACC2) ? (sp + ADDR_W'(2)) : (sp + ADDR_W'(1));
         end
         default: mem_addr_d = sp;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         kind_q      <= K_ALU;
         wb_q        <= 1'b0;
         rdst_q      <= '0;
         alu_q       <= '0;
         rsrc_q      <= '0;
         npc_q       <= '0;
         lo_q        <= '0;
         wb_valid_q  <= 1'b0;
         wb_value_q  <= '0;
         wb_rdst_q   <= '0;
         pc_load_q   <= 1'b0;
         pc_target_q <= '0;
         rti_done_q  <= 1'b0;
      end else begin
         wb_valid_q <= 1'b0;
         pc_load_q  <= 1'b0;
         rti_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.ExValid) begin
                  kind_q <= ex_kind;
                  wb_q   <= bus.ExWB;
                  rdst_q <= bus.ExRdstAddr;
                  alu_q  <= bus.ExAluResult;
                  rsrc_q <= bus.ExRsrcValue;
                  npc_q  <= bus.ExNextPC;
                  if (is_mem_op(ex_kind)) begin
                     state_q <= ST_ACC1;
                  end else begin
                     // Register-only ops finish on the accepting edge.
                     wb_valid_q <= bus.ExWB;
                     wb_rdst_q  <= bus.ExRdstAddr;
                     wb_value_q <= (ex_kind == K_IN) ? bus.ExInPort : bus.ExAluResult;
                  end
               end
            end
            ST_ACC1: begin
               if (bus.MemReady) begin
                  if (is_two_word(kind_q)) begin
                     state_q <= ST_ACC2;
                     if (kind_q != K_CALL) begin
                        lo_q <= bus.MemRData;
                     end
                  end else begin
                     state_q    <= ST_IDLE;
                     wb_valid_q <= wb_q;
                     wb_rdst_q  <= rdst_q;
                     wb_value_q <= ((kind_q == K_POP) || (kind_q == K_LDD)) ? bus.MemRData : alu_q;
                  end
               end
            end
            ST_ACC2: begin
               if (bus.MemReady) begin
                  state_q     <= ST_IDLE;
                  wb_valid_q  <= wb_q;
                  wb_rdst_q   <= rdst_q;
                  wb_value_q  <= alu_q;
                  pc_load_q   <= 1'b1;
                  pc_target_q <= (kind_q == K_CALL) ? {16'h0000, alu_q} : {bus.MemRData, lo_q};
                  rti_done_q  <= (kind_q == K_RTI);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.Stall      = busy;
   assign bus.MemReq     = busy;
   assign bus.MemWe      = busy & mem_we_d;
   assign bus.MemAddr    = mem_addr_d;
   assign bus.MemWData   = mem_wdata_d;
   assign bus.WbValid    = wb_valid_q;
   assign bus.WbValue    = wb_value_q;
   assign bus.WbRdstAddr = wb_rdst_q;
   assign bus.PcLoad     = pc_load_q;
   assign bus.PcTarget   = pc_target_q;
   assign bus.RtiDone    = rti_done_q;
   assign bus.Sp         = sp;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage

`timescale 1ns/1ps

module tb_memory_stage;

   localparam int AW = 20;
   localparam logic [AW-1:0] SPR = 20'hFFFFF;

   typedef struct {
      logic [7:0]  op;
      logic        wb;
      logic [2:0]  rdst;
      logic [15:0] alu;
      logic [15:0] rsrc;
      logic [15:0] inp;
      logic [31:0] npc;
   } instr_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [15:0]   wdata;
   } acc_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   memory_stage_if #(.ADDR_W(AW)) bus();

   memory_stage #(.ADDR_W(AW), .SP_RESET(SPR)) dut (
      .CLK   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // reference state
   logic [AW-1:0] m_sp;
   logic [15:0]   mem [logic [AW-1:0]];
   acc_t          m_accs[$];
   logic          r_def, r_pcl, r_rti;
   logic [15:0]   r_val;
   logic [31:0]   r_pct;
   logic [AW-1:0] r_sp_next;

   // expected outputs for the current cycle
   logic          e_en = 1'b0;
   logic          e_stall, e_req, e_we, e_wbv, e_wbval_def, e_pcl, e_rti;
   logic [AW-1:0] e_addr, e_sp;
   logic [15:0]   e_wdata, e_wbval;
   logic [2:0]    e_rdst;
   logic [31:0]   e_pct;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rd(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return a[15:0] ^ 16'h5A3C;
   endfunction

   function automatic instr_t mk(input logic [7:0] op, input logic wb, input logic [2:0] rdst,
                                 input logic [15:0] alu, input logic [15:0] rsrc,
                                 input logic [15:0] inp, input logic [31:0] npc);
      instr_t i;
      i.op = op; i.wb = wb; i.rdst = rdst; i.alu = alu; i.rsrc = rsrc; i.inp = inp; i.npc = npc;
      return i;
   endfunction

   // Transaction-level reference: list of word accesses plus the final result.
   task automatic model_instr(input instr_t ins);
      logic [AW-1:0] sp1, sp2, spm1, ea;
      sp1  = m_sp + 20'd1;
      sp2  = m_sp + 20'd2;
      spm1 = m_sp - 20'd1;
      ea   = {4'h0, ins.alu};
      m_accs.delete();
      r_def = 1'b0; r_pcl = 1'b0; r_rti = 1'b0; r_val = '0; r_pct = '0;
      r_sp_next = m_sp;
      if (ins.op[2]) begin
         m_accs.push_back('{m_sp, 1'b1, ins.npc[31:16]});
         m_accs.push_back('{spm1, 1'b1, ins.npc[15:0]});
         r_sp_next = m_sp - 20'd2;
         r_pcl = 1'b1;
         r_pct = {16'h0000, ins.alu};
      end else if (ins.op[3] || ins.op[4]) begin
         m_accs.push_back('{sp1, 1'b0, 16'h0});
         m_accs.push_back('{sp2, 1'b0, 16'h0});
         r_sp_next = sp2;
         r_pcl = 1'b1;
         r_pct = {rd(sp2), rd(sp1)};
         r_rti = !ins.op[3];
      end else if (ins.op[0]) begin
         m_accs.push_back('{m_sp, 1'b1, ins.rsrc});
         r_sp_next = spm1;
      end else if (ins.op[1]) begin
         m_accs.push_back('{sp1, 1'b0, 16'h0});
         r_sp_next = sp1;
         r_def = 1'b1; r_val = rd(sp1);
      end else if (ins.op[6]) begin
         m_accs.push_back('{ea, 1'b0, 16'h0});
         r_def = 1'b1; r_val = rd(ea);
      end else if (ins.op[5]) begin
         m_accs.push_back('{ea, 1'b1, ins.rsrc});
      end else if (ins.op[7]) begin
         r_def = 1'b1; r_val = ins.inp;
      end else begin
         r_def = 1'b1; r_val = ins.alu;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_idle();
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_wbv = 1'b0; e_wbval_def = 1'b0;
      e_pcl = 1'b0; e_rti = 1'b0; e_sp = m_sp;
   endtask

   task automatic exp_complete(input instr_t ins);
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0;
      e_wbv = ins.wb; e_rdst = ins.rdst;
      e_wbval_def = r_def; e_wbval = r_val;
      e_pcl = r_pcl; e_pct = r_pct; e_rti = r_rti; e_sp = m_sp;
   endtask

   // One compare process: every cycle, DUT outputs against the expectation.
   always @(negedge clk) begin
      if (e_en) begin
         chk("stall", bus.Stall, e_stall);
         chk("mem_req", bus.MemReq, e_req);
         if (e_req) begin
            chk("mem_addr", bus.MemAddr, e_addr);
            chk("mem_we", bus.MemWe, e_we);
            if (e_we) chk("mem_wdata", bus.MemWData, e_wdata);
         end
         chk("wb_valid", bus.WbValid, e_wbv);
         if (e_wbv) chk("wb_rdst", bus.WbRdstAddr, e_rdst);
         if (e_wbval_def) chk("wb_value", bus.WbValue, e_wbval);
         chk("pc_load", bus.PcLoad, e_pcl);
         if (e_pcl) chk("pc_target", bus.PcTarget, e_pct);
         chk("rti_done", bus.RtiDone, e_rti);
         chk("sp", bus.Sp, e_sp);
      end
   end

   // Called at posedge+1 in an idle cycle. fixed_delay<0 picks random wait
   // states; abort_acc>=0 asserts Reset in the first cycle of that access.
   task automatic run_instr(input instr_t ins, input int fixed_delay, input int abort_acc);
      int d;
      bus.ExValid = 1'b1; bus.ExOp = ins.op; bus.ExWB = ins.wb; bus.ExRdstAddr = ins.rdst;
      bus.ExAluResult = ins.alu; bus.ExRsrcValue = ins.rsrc; bus.ExInPort = ins.inp; bus.ExNextPC = ins.npc;
      model_instr(ins);
      step();
      if (m_accs.size() == 0) begin
         bus.ExValid = 1'b0;
         exp_complete(ins);
         return;
      end
      // operands must be ignored while stalled
      bus.ExValid = 1'($urandom); bus.ExOp = 8'($urandom); bus.ExWB = 1'($urandom);
      bus.ExRdstAddr = 3'($urandom); bus.ExAluResult = 16'($urandom); bus.ExRsrcValue = 16'($urandom);
      bus.ExInPort = 16'($urandom); bus.ExNextPC = $urandom;
      for (int k = 0; k < m_accs.size(); k++) begin
         d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
         for (int c = 0; c <= d; c++) begin
            e_stall = 1'b1; e_req = 1'b1; e_addr = m_accs[k].addr; e_we = m_accs[k].we;
            e_wdata = m_accs[k].wdata; e_wbv = 1'b0; e_wbval_def = 1'b0; e_pcl = 1'b0;
            e_rti = 1'b0; e_sp = m_sp;
            if (k == abort_acc) begin
               rst = 1'b1; bus.MemReady = 1'b0;
               step();
               rst = 1'b0; bus.ExValid = 1'b0;
               m_sp = SPR;
               exp_idle();
               return;
            end
            bus.MemReady = (c == d);
            bus.MemRData = m_accs[k].we ? 16'($urandom) : rd(m_accs[k].addr);
            step();
            if (c == d && m_accs[k].we) mem[m_accs[k].addr] = m_accs[k].wdata;
         end
      end
      bus.MemReady = 1'b0;
      bus.ExValid = 1'b0;
      m_sp = r_sp_next;
      exp_complete(ins);
   endtask

   task automatic idle();
      bus.ExValid = 1'b0;
      step();
      exp_idle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.ExValid = 1'b0; bus.MemReady = 1'b0;
      m_sp = SPR;
      step();
      exp_idle();
      e_en = 1'b1;
      step();
      rst = 1'b0;
      exp_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      instr_t ins;
      int r;
      bus.ExValid = 1'b0; bus.ExOp = '0; bus.ExWB = 1'b0; bus.ExRdstAddr = '0;
      bus.ExAluResult = '0; bus.ExRsrcValue = '0; bus.ExInPort = '0; bus.ExNextPC = '0;
      bus.MemRData = '0; bus.MemReady = 1'b0;

      // reset state
      do_reset();
      chk("rst_sp", bus.Sp, 20'hFFFFF);
      chk("rst_stall", bus.Stall, 1'b0);
      chk("rst_memreq", bus.MemReq, 1'b0);
      chk("rst_wbvalid", bus.WbValid, 1'b0);
      chk("rst_pcload", bus.PcLoad, 1'b0);

      // PUSH with ready tied high
      ins = mk(8'h01, 1'b0, 3'd0, 16'h0000, 16'h1234, 16'h0, 32'h0);
      model_instr(ins);
      chk("model_push_addr", m_accs[0].addr, 20'hFFFFF);
      chk("model_push_data", m_accs[0].wdata, 16'h1234);
      run_instr(ins, 0, -1);
      chk("push_sp", bus.Sp, 20'hFFFFE);
      idle();

      // CALL then RET immediately
      do_reset();
      ins = mk(8'h04, 1'b0, 3'd0, 16'h0200, 16'h0, 16'h0, 32'h0001_0ABC);
      model_instr(ins);
      chk("model_call_a0", m_accs[0].addr, 20'hFFFFF);
      chk("model_call_d0", m_accs[0].wdata, 16'h0001);
      chk("model_call_a1", m_accs[1].addr, 20'hFFFFE);
      chk("model_call_d1", m_accs[1].wdata, 16'h0ABC);
      run_instr(ins, -1, -1);
      chk("call_pcload", bus.PcLoad, 1'b1);
      chk("call_target", bus.PcTarget, 32'h0000_0200);
      chk("call_sp", bus.Sp, 20'hFFFFD);
      ins = mk(8'h08, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 32'h0);
      model_instr(ins);
      chk("model_ret_a0", m_accs[0].addr, 20'hFFFFE);
      chk("model_ret_a1", m_accs[1].addr, 20'hFFFFF);
      run_instr(ins, -1, -1);
      chk("ret_target", bus.PcTarget, 32'h0001_0ABC);
      chk("ret_sp", bus.Sp, 20'hFFFFF);
      chk("ret_rtidone", bus.RtiDone, 1'b0);
      run_instr(mk(8'h04, 1'b0, 3'd0, 16'h0200, 16'h0, 16'h0, 32'h0001_0ABC), -1, -1);
      run_instr(mk(8'h10, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 32'h0), -1, -1);
      chk("rti_target", bus.PcTarget, 32'h0001_0ABC);
      chk("rti_rtidone", bus.RtiDone, 1'b1);
      idle();

      // LDD with three wait cycles
      do_reset();
      mem[20'h00040] = 16'hBEEF;
      run_instr(mk(8'h40, 1'b1, 3'd5, 16'h0040, 16'h0, 16'h0, 32'h0), 3, -1);
      chk("ldd_wbvalid", bus.WbValid, 1'b1);
      chk("ldd_value", bus.WbValue, 16'hBEEF);
      chk("ldd_rdst", bus.WbRdstAddr, 3'd5);
      idle();

      // POP at top of memory wraps to 0
      do_reset();
      mem[20'h00000] = 16'h7777;
      ins = mk(8'h02, 1'b1, 3'd2, 16'h0, 16'h0, 16'h0, 32'h0);
      model_instr(ins);
      chk("model_pop_addr", m_accs[0].addr, 20'h00000);
      run_instr(ins, -1, -1);
      chk("pop_sp", bus.Sp, 20'h00000);
      chk("pop_value", bus.WbValue, 16'h7777);
      idle();

      // Reset during ACC2 of CALL
      do_reset();
      run_instr(mk(8'h04, 1'b0, 3'd0, 16'h0300, 16'h0, 16'h0, 32'h0002_0004), 0, 1);
      chk("abort_memreq", bus.MemReq, 1'b0);
      chk("abort_sp", bus.Sp, 20'hFFFFF);
      chk("abort_pcload", bus.PcLoad, 1'b0);
      for (int i = 0; i < 3; i++) idle();

      // randomized instruction stream
      do_reset();
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      ins.op = 8'h00;
         else if (r == 9) ins.op = 8'($urandom);
         else             ins.op = 8'(1 << (r - 1));
         ins.wb = 1'($urandom); ins.rdst = 3'($urandom);
         ins.alu = 16'($urandom); ins.rsrc = 16'($urandom);
         ins.inp = 16'($urandom); ins.npc = $urandom;
         run_instr(ins, -1, -1);
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      e_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
